// File: rtl/dram_line_adapter.sv
// Cache-line to DRAM-burst adapter: turns one 256-bit line read/write into a
// 4-beat 64-bit burst on one arbiter requester port, filtering foreign read beats.
module dram_line_adapter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         dfp_addr,
  input  logic                      dfp_read,
  input  logic                      dfp_write,
  input  logic [BEAT_W*BEATS-1:0]   dfp_wdata,
  output logic [BEAT_W*BEATS-1:0]   dfp_rdata,
  output logic                      dfp_resp,
  output logic [ADDR_W-1:0]         dram_addr,
  output logic                      dram_read,
  output logic                      dram_write,
  output logic [BEAT_W-1:0]         dram_wdata,
  input  logic                      dram_ready,
  input  logic [ADDR_W-1:0]         dram_raddr,
  input  logic [BEAT_W-1:0]         dram_rdata,
  input  logic                      dram_rvalid
);

  localparam int unsigned LINE_W     = BEAT_W * BEATS;
  localparam int unsigned LINE_BYTES = LINE_W / 8;
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BEAT_W-1:0] line [BEATS];

  logic [ADDR_W-1:0] line_addr_c;
  logic [CNT_W-1:0]  cnt_next_c;
  logic              beat_hit_c;
  logic              wr_issue_c;
  logic [LINE_W-1:0] full_line_c;

  // dram_addr holds the latched line address for the whole transaction
  assign line_addr_c = dfp_addr & LINE_MASK;
  assign cnt_next_c  = (cnt == LAST_BEAT) ? '0 : cnt + CNT_W'(1);
  assign beat_hit_c  = dram_rvalid && (dram_raddr == dram_addr);
  // First write beat waits for ready; the rest follow back-to-back until cnt wraps
  assign wr_issue_c  = dram_write ? (cnt != '0) : dram_ready;

  // Completed read line: stored beats plus the final beat arriving this cycle
  always_comb begin
    full_line_c = '0;
    for (int i = 0; i < int'(BEATS); i++) begin
      full_line_c[i*BEAT_W +: BEAT_W] = (i == int'(BEATS) - 1) ? dram_rdata : line[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dfp_resp   <= 1'b0;
      dfp_rdata  <= '0;
      dram_addr  <= '0;
      dram_read  <= 1'b0;
      dram_write <= 1'b0;
      dram_wdata <= '0;
      for (int i = 0; i < int'(BEATS); i++) begin
        line[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (dfp_write || dfp_read) begin
            dram_addr <= line_addr_c;
            for (int i = 0; i < int'(BEATS); i++) begin
              line[i] <= dfp_wdata[i*BEAT_W +: BEAT_W];
            end
            state <= dfp_write ? WR : RD_REQ;
          end
        end
        RD_REQ: begin
          if (dram_ready) begin
            dram_read <= 1'b1;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          dram_read <= 1'b0;
          if (beat_hit_c) begin
            line[cnt] <= dram_rdata;
            cnt       <= cnt_next_c;
            if (cnt == LAST_BEAT) begin
              dfp_rdata <= full_line_c;
              dfp_resp  <= 1'b1;
              state     <= DONE;
            end
          end
        end
        WR: begin
          if (wr_issue_c) begin
            dram_write <= 1'b1;
            dram_wdata <= line[cnt];
            cnt        <= cnt_next_c;
          end else if (dram_write) begin
            dram_write <= 1'b0;
            dram_wdata <= '0;
            dfp_resp   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          dfp_resp <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_line_adapter.sv
// Self-checking bench for dram_line_adapter: directed table, abort-by-reset
// sequence and randomized transactions against a transaction-level model.
module tb_dram_line_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  dram_addr;
  logic         dram_read;
  logic         dram_write;
  logic [63:0]  dram_wdata;
  logic         dram_ready;
  logic [31:0]  dram_raddr;
  logic [63:0]  dram_rdata;
  logic         dram_rvalid;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_line;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           stall;
    int           foreign;
    logic [31:0]  faddr;
    logic [31:0]  exp_addr;
    logic [255:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [63:0] d;
    logic        m;
  } beat_t;

  vec_t vecs[5];

  dram_line_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .dram_addr   (dram_addr),
    .dram_read   (dram_read),
    .dram_write  (dram_write),
    .dram_wdata  (dram_wdata),
    .dram_ready  (dram_ready),
    .dram_raddr  (dram_raddr),
    .dram_rdata  (dram_rdata),
    .dram_rvalid (dram_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, dfp_rdata, 256'(0));
    chk({tag, "_resp"}, 256'(dfp_resp), 256'(0));
    chk({tag, "_addr"}, 256'(dram_addr), 256'(0));
    chk({tag, "_read"}, 256'(dram_read), 256'(0));
    chk({tag, "_write"}, 256'(dram_write), 256'(0));
    chk({tag, "_wdata"}, 256'(dram_wdata), 256'(0));
  endtask

  // Drives one line transaction as cache + memory and checks the observed burst.
  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] data, input int stall, input int foreign,
                         input logic gaps, input logic [31:0] faddr,
                         input logic [31:0] exp_addr, input logic [255:0] exp_rdata);
    beat_t q[$];
    beat_t b;
    int cyc, nrd, nwr, rd_cyc, first_wr_cyc, last_wr_cyc, last_match_cyc, resp_cyc, exp_start;
    for (int k = 0; k < 4; k++) begin
      for (int f = 0; f < foreign; f++) q.push_back('{1'b1, faddr, {$urandom, $urandom}, 1'b0});
      if (gaps && $urandom_range(0, 1) == 1) q.push_back('{1'b0, 32'h0, 64'h0, 1'b0});
      q.push_back('{1'b1, exp_addr, data[64*k +: 64], 1'b1});
    end
    exp_start = (stall + 1 > 2) ? stall + 1 : 2;
    nrd = 0; nwr = 0; rd_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    last_match_cyc = -1; resp_cyc = -1; cyc = 0;
    @(negedge clk);
    dfp_addr    = addr;
    dfp_read    = rd;
    dfp_write   = wr;
    dfp_wdata   = wr ? data : ~data;
    dram_ready  = (stall == 0);
    dram_rvalid = 1'b0;
    while (resp_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (dram_read) begin
        nrd++;
        rd_cyc = cyc;
        chk("rd_addr", 256'(dram_addr), 256'(exp_addr));
      end
      if (dram_write) begin
        if (nwr < 4) chk("wr_data", 256'(dram_wdata), 256'(data[64*nwr +: 64]));
        chk("wr_addr", 256'(dram_addr), 256'(exp_addr));
        if (nwr == 0) first_wr_cyc = cyc;
        else chk("wr_consecutive", 256'(cyc), 256'(last_wr_cyc + 1));
        last_wr_cyc = cyc;
        nwr++;
      end
      if (dfp_resp) begin
        resp_cyc = cyc;
        chk("resp_rdata", dfp_rdata, exp_rdata);
      end
      dram_ready  = (cyc >= stall);
      dram_rvalid = 1'b0;
      dram_raddr  = $urandom;
      dram_rdata  = {$urandom, $urandom};
      if (resp_cyc >= 0) begin
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
      end else if (!wr && nrd > 0 && q.size() > 0) begin
        b = q.pop_front();
        dram_rvalid = b.v;
        dram_raddr  = b.a;
        dram_rdata  = b.d;
        if (b.m) last_match_cyc = cyc;
      end else if (wr && $urandom_range(0, 2) == 0) begin
        // stray response tagged with our own line must not touch the read line
        dram_rvalid = 1'b1;
        dram_raddr  = exp_addr;
      end
    end
    dram_rvalid = 1'b0;
    chk("resp_seen", 256'(resp_cyc >= 0), 256'(1));
    if (wr) begin
      chk("wr_no_read", 256'(nrd), 256'(0));
      chk("wr_beats", 256'(nwr), 256'(4));
      chk("wr_start", 256'(first_wr_cyc), 256'(exp_start));
      chk("wr_resp_lat", 256'(resp_cyc), 256'(last_wr_cyc + 1));
    end else begin
      chk("rd_pulses", 256'(nrd), 256'(1));
      chk("rd_no_write", 256'(nwr), 256'(0));
      chk("rd_start", 256'(rd_cyc), 256'(exp_start));
      chk("rd_resp_lat", 256'(resp_cyc), 256'(last_match_cyc + 1));
      chk("rd_beats_left", 256'(q.size()), 256'(0));
    end
    @(negedge clk);
    chk("resp_one_cycle", 256'(dfp_resp), 256'(0));
    chk("idle_quiet", 256'({dram_read, dram_write}), 256'(0));
    chk("rdata_stable", dfp_rdata, exp_rdata);
  endtask

  initial begin
    logic [31:0]  addr, ea;
    logic [255:0] data;
    logic         rd, wr, seen;
    int           op, n;

    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    dram_ready = 1'b0; dram_raddr = '0; dram_rdata = '0; dram_rvalid = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                0, 0, 32'h0000_2000, 32'h0000_1220,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{1'b0, 1'b1, 32'h8000_0040,
                {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2, 64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0},
                0, 0, 32'h0000_2000, 32'h8000_0040,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_5678,
                {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000},
                5, 0, 32'h0000_2000, 32'h0000_5660,
                {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000}};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_1234,
                {64'hB3B3_B3B3_0000_1111, 64'hB2B2_B2B2_0000_1111, 64'hB1B1_B1B1_0000_1111, 64'hB0B0_B0B0_0000_1111},
                0, 1, 32'h0000_2000, 32'h0000_1220,
                {64'hB3B3_B3B3_0000_1111, 64'hB2B2_B2B2_0000_1111, 64'hB1B1_B1B1_0000_1111, 64'hB0B0_B0B0_0000_1111}};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_00FF,
                {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0},
                2, 0, 32'h0000_2000, 32'h0000_00E0,
                {64'hB3B3_B3B3_0000_1111, 64'hB2B2_B2B2_0000_1111, 64'hB1B1_B1B1_0000_1111, 64'hB0B0_B0B0_0000_1111}};

    // reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].stall,
              vecs[i].foreign, 1'b0, vecs[i].faddr, vecs[i].exp_addr, vecs[i].exp_rdata);
    end

    // asynchronous reset after two beats of a read
    @(negedge clk);
    dfp_addr = 32'h0000_1234; dfp_read = 1'b1; dram_ready = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (dram_read) seen = 1'b1;
    end
    chk("abort_rd_pulse", 256'(seen), 256'(1));
    dram_rvalid = 1'b1; dram_raddr = 32'h0000_1220; dram_rdata = 64'hEEEE_0000_0000_0000;
    @(negedge clk);
    dram_rdata = 64'hEEEE_0000_0000_0001;
    @(negedge clk);
    dram_rvalid = 1'b0;
    chk("abort_pre_addr", 256'(dram_addr), 256'(32'h0000_1220));
    #1 rst = 1'b1;
    dfp_read = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_resp", 256'(dfp_resp), 256'(0));
    end
    rst = 1'b0;
    last_line = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
    run_txn(1'b1, 1'b0, 32'h0000_1234, last_line, 0, 0, 1'b0, 32'h0000_2000, 32'h0000_1220, last_line);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      op   = $urandom_range(0, 9);
      rd   = (op < 5) || (op == 9);
      wr   = (op >= 5);
      addr = $urandom;
      for (int w = 0; w < 8; w++) data[32*w +: 32] = $urandom;
      ea = addr & 32'hFFFF_FFE0;
      if (!wr) last_line = data;
      run_txn(rd, wr, addr, data, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1,
              ea ^ 32'h0000_0100, ea, last_line);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
